// File: rtl/quantum_rng_scheduler_if.sv
// Request/entropy/delivery bundle for quantum_rng_scheduler.
// The scheduler takes the slave side; requesters, the entropy source and the consumer take the master side.
interface quantum_rng_scheduler_if #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 8,
    parameter int CNT_W  = 16
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic              src_bit;
    logic              src_valid;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_id;
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              busy;
    logic [CNT_W-1:0]  words_cnt;

    modport slave (
        input  src_bit, src_valid, req, data_ready,
        output grant, grant_id, data_out, data_valid, busy, words_cnt
    );

    modport master (
        output src_bit, src_valid, req, data_ready,
        input  grant, grant_id, data_out, data_valid, busy, words_cnt
    );
endinterface

// File: rtl/quantum_rng_scheduler.sv
// Round-robin scheduler handing whole random words, built from a shared entropy bit stream, to NREQ requesters.
// Optional von Neumann debiasing of source bit pairs: define QRNG_VON_NEUMANN_EN.
module quantum_rng_scheduler #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    quantum_rng_scheduler_if.slave  bus
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BC_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DELIVER
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NREQ-1:0]   r_grant;
    logic [ID_W-1:0]   r_grant_id;
    logic [ID_W-1:0]   r_rr;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_data;
    logic              r_data_valid;
    logic [BC_W-1:0]   r_bitcnt;
    logic [CNT_W-1:0]  r_words;

    logic              w_any;
    logic [ID_W-1:0]   w_pick;
    logic              w_req_held;
    logic              w_bit_take;
    logic              w_bit_val;
    logic              w_last;
    logic [WORD_W-1:0] w_shift_nxt;
    logic [ID_W-1:0]   w_rr_nxt;

`ifdef QRNG_VON_NEUMANN_EN
    logic r_phase;
    logic r_first;
`endif

    // First asserted request at or above the rr pointer, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        w_any  = 1'b0;
        w_pick = '0;
        idx    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(r_rr) + i) % NREQ;
            if (!w_any && bus.req[idx]) begin
                w_any  = 1'b1;
                w_pick = ID_W'(idx);
            end
        end
    end

    always_comb begin
        w_req_held = bus.req[r_grant_id];
`ifdef QRNG_VON_NEUMANN_EN
        // Second bit of a pair yields an output bit only when it differs; 10 -> 1, 01 -> 0.
        w_bit_take = bus.src_valid && r_phase && (r_first != bus.src_bit);
        w_bit_val  = r_first;
`else
        w_bit_take = bus.src_valid;
        w_bit_val  = bus.src_bit;
`endif
        w_shift_nxt = {r_shift[WORD_W-2:0], w_bit_val};
        w_last      = w_bit_take && (r_bitcnt == BC_W'(WORD_W - 1));
        w_rr_nxt    = (r_grant_id == ID_W'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) w_state_nxt = COLLECT;
            end
            COLLECT: begin
                if (!w_req_held) w_state_nxt = IDLE;
                else if (w_last) w_state_nxt = DELIVER;
            end
            DELIVER: begin
                if (bus.data_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= '0;
            r_grant_id   <= '0;
            r_rr         <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_bitcnt     <= '0;
            r_words      <= '0;
`ifdef QRNG_VON_NEUMANN_EN
            r_phase      <= 1'b0;
            r_first      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant    <= NREQ'(1) << w_pick;
                        r_grant_id <= w_pick;
                        r_bitcnt   <= '0;
                        r_shift    <= '0;
`ifdef QRNG_VON_NEUMANN_EN
                        r_phase    <= 1'b0;
`endif
                    end
                end
                COLLECT: begin
                    if (!w_req_held) begin
                        // Abort: partial word discarded, rr pointer left alone.
                        r_grant  <= '0;
                        r_bitcnt <= '0;
                        r_shift  <= '0;
`ifdef QRNG_VON_NEUMANN_EN
                        r_phase  <= 1'b0;
`endif
                    end else begin
`ifdef QRNG_VON_NEUMANN_EN
                        if (bus.src_valid) begin
                            r_phase <= ~r_phase;
                            if (!r_phase) r_first <= bus.src_bit;
                        end
`endif
                        if (w_bit_take) begin
                            r_shift  <= w_shift_nxt;
                            r_bitcnt <= r_bitcnt + 1'b1;
                            if (w_last) begin
                                r_data       <= w_shift_nxt;
                                r_data_valid <= 1'b1;
                            end
                        end
                    end
                end
                DELIVER: begin
                    if (bus.data_ready) begin
                        r_data_valid <= 1'b0;
                        r_grant      <= '0;
                        r_rr         <= w_rr_nxt;
                        r_words      <= r_words + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.grant      = r_grant;
    assign bus.grant_id   = r_grant_id;
    assign bus.data_out   = r_data;
    assign bus.data_valid = r_data_valid;
    assign bus.busy       = (r_state != IDLE);
    assign bus.words_cnt  = r_words;
endmodule

// File: tb/tb_quantum_rng_scheduler.sv
// Scoreboard bench for quantum_rng_scheduler: a transaction-level model queues expected words, a monitor checks deliveries.
module tb_quantum_rng_scheduler;
    localparam int NREQ   = 4;
    localparam int WORD_W = 8;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    quantum_rng_scheduler_if #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

    quantum_rng_scheduler #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = idle, 1 = collecting for m_owner, 2 = word pending.
    typedef struct { int id; int word; } exp_t;
    exp_t        sb[$];
    int          m_bits[$];
    int          m_mode = 0;
    int          m_owner = 0;
    int          m_rr = 0;
    int unsigned m_words = 0;
    int          m_first = 0;
    bit          m_have_first = 0;
    int          glog[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_owner = 0; m_rr = 0; m_words = 0; m_have_first = 0;
            m_bits.delete(); sb.delete();
        end else begin
            case (m_mode)
                0: if (bus.req != '0) begin
                    for (int k = 0; k < NREQ; k++)
                        if (bus.req[(m_rr + k) % NREQ]) begin
                            m_owner = (m_rr + k) % NREQ;
                            break;
                        end
                    m_mode = 1;
                    m_bits.delete();
                    m_have_first = 0;
                end
                1: if (!bus.req[m_owner]) begin
                    m_mode = 0;
                end else if (bus.src_valid) begin
`ifdef QRNG_VON_NEUMANN_EN
                    if (!m_have_first) begin
                        m_first = int'(bus.src_bit);
                        m_have_first = 1;
                    end else begin
                        m_have_first = 0;
                        if (m_first != int'(bus.src_bit)) m_bits.push_back(m_first);
                    end
`else
                    m_bits.push_back(int'(bus.src_bit));
`endif
                    if (m_bits.size() == WORD_W) begin
                        int w;
                        w = 0;
                        foreach (m_bits[j]) w = w * 2 + m_bits[j];
                        sb.push_back('{m_owner, w});
                        m_mode = 2;
                    end
                end
                2: if (bus.data_ready) begin
                    m_mode = 0;
                    m_rr = (m_owner + 1) % NREQ;
                    m_words++;
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("grant", 32'(bus.grant), (m_mode != 0) ? (32'd1 << m_owner) : 32'd0);
            chk("busy", 32'(bus.busy), 32'(m_mode != 0));
            chk("data_valid", 32'(bus.data_valid), 32'(m_mode == 2));
            chk("words_cnt", 32'(bus.words_cnt), 32'(CNT_W'(m_words)));
            if (bus.data_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", bus.data_out);
                end else begin
                    chk("grant_id", 32'(bus.grant_id), 32'(sb[0].id));
                    chk("data_out", 32'(bus.data_out), 32'(sb[0].word));
                    if (bus.data_ready) begin
                        glog.push_back(sb[0].id);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input logic [NREQ-1:0] r, input logic v, input logic b, input logic rdy);
        @(posedge clk);
        #1;
        bus.req = r; bus.src_valid = v; bus.src_bit = b; bus.data_ready = rdy;
    endtask

    // Feed random bits to requester mask r until a word is presented.
    task automatic collect(input logic [NREQ-1:0] r, input bit toggle, input string name);
        for (int n = 0; n < 400; n++) begin
            if (bus.data_valid) break;
            drive(r, toggle ? n[0] : 1'b1, 1'($urandom_range(1)), 1'b0);
        end
        chk(name, 32'(bus.data_valid), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] cur;
        int pat[$];
`ifdef QRNG_VON_NEUMANN_EN
        pat = '{0,0, 0,1, 1,1, 1,0, 0,1, 1,0, 1,0, 0,1, 0,1, 1,0};
`else
        pat = '{1, 0, 1, 1, 0, 0, 1, 0};
`endif
        bus.req = '0; bus.src_valid = 1'b0; bus.src_bit = 1'b0; bus.data_ready = 1'b0;
        repeat (3) @(posedge clk);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_grant_id", 32'(bus.grant_id), 0);
        chk("rst_data_out", 32'(bus.data_out), 0);
        chk("rst_data_valid", 32'(bus.data_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_words", 32'(bus.words_cnt), 0);
        #1 rst_n = 1'b1;

        // Fixed bit pattern to requester 0.
        drive(4'b0001, 1'b0, 1'b0, 1'b0);
        foreach (pat[i]) drive(4'b0001, 1'b1, 1'(pat[i]), 1'b0);
        collect(4'b0001, 1'b0, "t1_valid");
`ifndef QRNG_VON_NEUMANN_EN
        chk("t1_word", 32'(bus.data_out), 32'hB2);
`endif
        drive(4'b0001, 1'b0, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("t1_words", 32'(bus.words_cnt), 1);

        // All requesting: round-robin continues from requester 1.
        glog.delete();
        for (int n = 0; n < 600; n++) begin
            drive((glog.size() >= 5) ? 4'b0000 : 4'b1111, 1'b1, 1'($urandom_range(1)), 1'b1);
            if (glog.size() >= 5) break;
        end
        chk("rr_count", glog.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("rr_order", (i < glog.size()) ? glog[i] : -1, (1 + i) % NREQ);
        chk("rr_words", 32'(bus.words_cnt), 6);

        // Sparse source bits.
        collect(4'b0010, 1'b1, "t3_valid");
        drive(4'b0010, 1'b0, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 1'b0, 1'b0);

        // Abort after three bits, then restart.
        drive(4'b0100, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(4'b0100, 1'b1, 1'($urandom_range(1)), 1'b0);
        drive(4'b0000, 1'b1, 1'b1, 1'b0);
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("abort_grant", 32'(bus.grant), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_words", 32'(bus.words_cnt), 7);
        collect(4'b0100, 1'b0, "t4_valid");
        drive(4'b0100, 1'b0, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 1'b0, 1'b0);

        // Consumer stall with request withdrawn.
        collect(4'b1000, 1'b0, "t5_valid");
        for (int i = 0; i < 10; i++) begin
            drive(4'b0000, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
            chk("stall_valid", 32'(bus.data_valid), 1);
            chk("stall_data", 32'(bus.data_out), (sb.size() != 0) ? 32'(sb[0].word) : 32'hFFFF_FFFF);
            chk("stall_words", 32'(bus.words_cnt), 8);
        end
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("stall_release_words", 32'(bus.words_cnt), 9);

        // Asynchronous reset in the middle of collection.
        drive(4'b0001, 1'b1, 1'b1, 1'b0);
        drive(4'b0001, 1'b1, 1'b1, 1'b0);
        drive(4'b0001, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(bus.grant), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_valid", 32'(bus.data_valid), 0);
        chk("arst_data", 32'(bus.data_out), 0);
        chk("arst_words", 32'(bus.words_cnt), 0);
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Randomised traffic.
        cur = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(15) == 0) cur = NREQ'($urandom);
            drive(cur, $urandom_range(3) != 0, 1'($urandom_range(1)), $urandom_range(2) != 0);
        end
        repeat (100) drive(4'b0000, 1'b0, 1'b0, 1'b1);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
